exe_cond_unit: RTL and testbench

EXE_COND_UNIT -- requirements
Module: exe_cond_unit

---
 rtl/exe_cond_unit_if.sv | 38 +++
 rtl/exe_cond_unit.sv | 146 ++++++++++++++
 tb/tb_exe_cond_unit.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/exe_cond_unit_if.sv
// Execute-stage condition unit bus: raw Decode controls and ALU flags in,
// condition-gated controls, flush requests, flags and event counters out.
interface exe_cond_unit_if;
  logic        ValidE;
  logic        StallE;
  logic [3:0]  CondE;
  logic [1:0]  FlagWriteE;
  logic        PCSrcE;
  logic        RegWriteE;
  logic        MemWriteE;
  logic        BranchE;
  logic [3:0]  ALUFlags;

  logic        PCSrcG;
  logic        RegWriteG;
  logic        MemWriteG;
  logic        CondExE;
  logic [3:0]  FlagsOut;
  logic        FlushD;
  logic        FlushE;
  logic        RedirectV;
  logic [15:0] ExecCnt;
  logic [15:0] SquashCnt;

  modport master (
    output ValidE, StallE, CondE, FlagWriteE, PCSrcE, RegWriteE, MemWriteE,
           BranchE, ALUFlags,
    input  PCSrcG, RegWriteG, MemWriteG, CondExE, FlagsOut, FlushD, FlushE,
           RedirectV, ExecCnt, SquashCnt
  );

  modport slave (
    input  ValidE, StallE, CondE, FlagWriteE, PCSrcE, RegWriteE, MemWriteE,
           BranchE, ALUFlags,
    output PCSrcG, RegWriteG, MemWriteG, CondExE, FlagsOut, FlushD, FlushE,
           RedirectV, ExecCnt, SquashCnt
  );
endinterface

// File: rtl/exe_cond_unit.sv
// ARM-style conditional execution unit for the Execute stage: evaluates the
// condition against architectural flags, gates side effects, and tracks redirects.
module exe_cond_unit (
  input logic            clk,
  input logic            reset,
  exe_cond_unit_if.slave bus
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_REDIR = 1'b1;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  // Condition check over {N,Z,C,V}; AL and the unused encoding both pass.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v;
    logic res;
    n = flags[3];
    z = flags[2];
    c = flags[1];
    v = flags[0];
    case (cond)
      4'h0:    res = z;
      4'h1:    res = ~z;
      4'h2:    res = c;
      4'h3:    res = ~c;
      4'h4:    res = n;
      4'h5:    res = ~n;
      4'h6:    res = v;
      4'h7:    res = ~v;
      4'h8:    res = c & ~z;
      4'h9:    res = ~c | z;
      4'hA:    res = (n == v);
      4'hB:    res = (n != v);
      4'hC:    res = ~z & (n == v);
      4'hD:    res = z | (n != v);
      4'hE:    res = 1'b1;
      4'hF:    res = 1'b1;
      default: res = 1'b1;
    endcase
    return res;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] cnt, input logic en);
    logic [15:0] res;
    if (en && (cnt != CNT_MAX)) begin
      res = cnt + 16'd1;
    end else begin
      res = cnt;
    end
    return res;
  endfunction

  logic [3:0]  flags_q, flags_d;
  logic [0:0]  state_q, state_d;
  logic        redirect_v_q, redirect_v_d;
  logic [15:0] exec_cnt_q, exec_cnt_d;
  logic [15:0] squash_cnt_q, squash_cnt_d;

  logic        cond_ex_s;
  logic        retire_s;
  logic        go_s;
  logic        squash_s;
  logic        taken_s;

  // Qualify the Execute instruction; the condition sees only registered flags.
  always_comb begin
    cond_ex_s = cond_pass(bus.CondE, flags_q);
    retire_s  = bus.ValidE & ~bus.StallE;
    go_s      = retire_s & cond_ex_s;
    squash_s  = retire_s & ~cond_ex_s;
    taken_s   = go_s & (bus.BranchE | bus.PCSrcE);
  end

  // Next-state flags: N,Z and C,V are written independently.
  always_comb begin
    flags_d = flags_q;
    if (go_s && bus.FlagWriteE[1]) begin
      flags_d[3:2] = bus.ALUFlags[3:2];
    end else begin
      flags_d[3:2] = flags_q[3:2];
    end
    if (go_s && bus.FlagWriteE[0]) begin
      flags_d[1:0] = bus.ALUFlags[1:0];
    end else begin
      flags_d[1:0] = flags_q[1:0];
    end
  end

  // Redirect FSM; a stall freezes it, a second taken redirect extends REDIR.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (taken_s) begin
          state_d = ST_REDIR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REDIR: begin
        if (bus.StallE || taken_s) begin
          state_d = ST_REDIR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    redirect_v_d = (state_d == ST_REDIR);
  end

  // Saturating event counters.
  always_comb begin
    exec_cnt_d   = sat_inc(exec_cnt_q, go_s);
    squash_cnt_d = sat_inc(squash_cnt_q, squash_s);
  end

  // State registers; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q      <= 4'b0000;
      state_q      <= ST_IDLE;
      redirect_v_q <= 1'b0;
      exec_cnt_q   <= 16'd0;
      squash_cnt_q <= 16'd0;
    end else begin
      flags_q      <= flags_d;
      state_q      <= state_d;
      redirect_v_q <= redirect_v_d;
      exec_cnt_q   <= exec_cnt_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

  assign bus.CondExE   = cond_ex_s;
  assign bus.PCSrcG    = bus.PCSrcE & go_s;
  assign bus.RegWriteG = bus.RegWriteE & go_s;
  assign bus.MemWriteG = bus.MemWriteE & go_s;
  assign bus.FlushD    = taken_s;
  assign bus.FlushE    = taken_s;
  assign bus.FlagsOut  = flags_q;
  assign bus.RedirectV = redirect_v_q;
  assign bus.ExecCnt   = exec_cnt_q;
  assign bus.SquashCnt = squash_cnt_q;

endmodule

// File: tb/tb_exe_cond_unit.sv
// Self-checking bench for exe_cond_unit: directed scenarios plus a randomized
// run against an abstract reference model of the condition/flag/counter rules.
module tb_exe_cond_unit;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  exe_cond_unit_if bus ();

  exe_cond_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference condition: pairs of encodings are a base test and its negation.
  function automatic bit ref_cond(input bit [3:0] cc, input bit [3:0] f);
    bit fn, fz, fc, fv, base;
    fn = f[3]; fz = f[2]; fc = f[1]; fv = f[0];
    if (cc >= 4'hE) return 1'b1;
    case (cc[3:1])
      3'd0:    base = fz;
      3'd1:    base = fc;
      3'd2:    base = fn;
      3'd3:    base = fv;
      3'd4:    base = fc && !fz;
      3'd5:    base = (fn == fv);
      3'd6:    base = !fz && (fn == fv);
      default: base = 1'b1;
    endcase
    return cc[0] ? !base : base;
  endfunction

  task automatic set_in(input bit v, input bit s, input bit [3:0] cond, input bit [1:0] fw,
                        input bit pc, input bit rw, input bit mw, input bit br,
                        input bit [3:0] alu);
    bus.ValidE = v; bus.StallE = s; bus.CondE = cond; bus.FlagWriteE = fw;
    bus.PCSrcE = pc; bus.RegWriteE = rw; bus.MemWriteE = mw; bus.BranchE = br;
    bus.ALUFlags = alu;
  endtask

  task automatic do_reset();
    set_in(0, 0, 4'h0, 2'b00, 0, 0, 0, 0, 4'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b0;
    #1;
    checks++; if (bus.FlagsOut !== 4'b0000) begin errors++; $display("FAIL reset_flags got=%b exp=0000", bus.FlagsOut); end
    checks++; if (bus.RedirectV !== 1'b0) begin errors++; $display("FAIL reset_redir got=%b exp=0", bus.RedirectV); end
    checks++; if (bus.ExecCnt !== 16'd0 || bus.SquashCnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%h/%h exp=0/0", bus.ExecCnt, bus.SquashCnt); end
    bus.CondE = 4'h1; #1;
    checks++; if (bus.CondExE !== 1'b1) begin errors++; $display("FAIL reset_cond_ne got=%b exp=1", bus.CondExE); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_eq_squash();
    do_reset();
    @(negedge clk);
    set_in(1, 0, 4'h0, 2'b00, 0, 1, 0, 0, 4'h0);
    #1;
    checks++; if (bus.CondExE !== 1'b0 || bus.RegWriteG !== 1'b0) begin errors++; $display("FAIL eq_squash_comb got=%b%b exp=00", bus.CondExE, bus.RegWriteG); end
    @(negedge clk);
    set_in(0, 0, 4'h0, 2'b00, 0, 0, 0, 0, 4'h0);
    #1;
    checks++; if (bus.SquashCnt !== 16'd1 || bus.ExecCnt !== 16'd0) begin errors++; $display("FAIL eq_squash_cnt got=%0d/%0d exp=1/0", bus.SquashCnt, bus.ExecCnt); end
  endtask

  task automatic test_flag_set();
    do_reset();
    @(negedge clk);
    set_in(1, 0, 4'hE, 2'b11, 0, 1, 0, 0, 4'b0100);
    #1;
    checks++; if (bus.CondExE !== 1'b1 || bus.FlagsOut !== 4'b0000) begin errors++; $display("FAIL flag_set_nobypass got=%b/%b exp=1/0000", bus.CondExE, bus.FlagsOut); end
    @(negedge clk);
    set_in(1, 0, 4'h0, 2'b00, 0, 1, 0, 0, 4'b0000);
    #1;
    checks++; if (bus.FlagsOut !== 4'b0100 || bus.CondExE !== 1'b1 || bus.RegWriteG !== 1'b1) begin errors++; $display("FAIL flag_set_use got=%b/%b/%b exp=0100/1/1", bus.FlagsOut, bus.CondExE, bus.RegWriteG); end
    @(negedge clk);
    set_in(0, 0, 4'h0, 2'b00, 0, 0, 0, 0, 4'h0);
    #1;
    checks++; if (bus.ExecCnt !== 16'd2) begin errors++; $display("FAIL flag_set_exec got=%0d exp=2", bus.ExecCnt); end
  endtask

  task automatic test_partial_flags();
    do_reset();
    @(negedge clk);
    set_in(1, 0, 4'hE, 2'b01, 0, 0, 0, 0, 4'b1111);
    @(negedge clk);
    set_in(1, 0, 4'hE, 2'b10, 0, 0, 0, 0, 4'b1000);
    #1;
    checks++; if (bus.FlagsOut !== 4'b0011) begin errors++; $display("FAIL partial_cv got=%b exp=0011", bus.FlagsOut); end
    @(negedge clk);
    set_in(0, 0, 4'h0, 2'b11, 0, 0, 0, 0, 4'b0000);
    #1;
    checks++; if (bus.FlagsOut !== 4'b1011) begin errors++; $display("FAIL partial_nz got=%b exp=1011", bus.FlagsOut); end
  endtask

  task automatic test_branch();
    do_reset();
    @(negedge clk);
    set_in(1, 0, 4'hE, 2'b00, 0, 0, 0, 1, 4'h0);
    #1;
    checks++; if (bus.FlushD !== 1'b1 || bus.FlushE !== 1'b1 || bus.RedirectV !== 1'b0) begin errors++; $display("FAIL branch_flush got=%b%b%b exp=110", bus.FlushD, bus.FlushE, bus.RedirectV); end
    @(negedge clk);
    set_in(0, 0, 4'hE, 2'b00, 0, 0, 0, 1, 4'h0);
    #1;
    checks++; if (bus.RedirectV !== 1'b1 || bus.FlushD !== 1'b0) begin errors++; $display("FAIL branch_redir got=%b/%b exp=1/0", bus.RedirectV, bus.FlushD); end
    @(negedge clk);
    #1;
    checks++; if (bus.RedirectV !== 1'b0) begin errors++; $display("FAIL branch_redir_end got=%b exp=0", bus.RedirectV); end
    do_reset();
    @(negedge clk);
    set_in(1, 1, 4'hE, 2'b11, 1, 1, 1, 1, 4'hF);
    #1;
    checks++; if (bus.FlushD !== 1'b0 || bus.FlushE !== 1'b0 || bus.PCSrcG !== 1'b0 || bus.MemWriteG !== 1'b0) begin errors++; $display("FAIL stall_flush got=%b%b%b%b exp=0000", bus.FlushD, bus.FlushE, bus.PCSrcG, bus.MemWriteG); end
    @(negedge clk);
    #1;
    checks++; if (bus.RedirectV !== 1'b0 || bus.ExecCnt !== 16'd0 || bus.SquashCnt !== 16'd0 || bus.FlagsOut !== 4'h0) begin errors++; $display("FAIL stall_hold got=%b/%0d/%0d/%b exp=0/0/0/0000", bus.RedirectV, bus.ExecCnt, bus.SquashCnt, bus.FlagsOut); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    @(negedge clk);
    set_in(1, 0, 4'hE, 2'b00, 0, 0, 0, 1, 4'h0);
    @(negedge clk);
    set_in(1, 0, 4'hE, 2'b00, 1, 0, 0, 0, 4'h0);
    #1;
    checks++; if (bus.RedirectV !== 1'b1 || bus.FlushE !== 1'b1) begin errors++; $display("FAIL b2b_first got=%b/%b exp=1/1", bus.RedirectV, bus.FlushE); end
    @(negedge clk);
    set_in(0, 0, 4'h0, 2'b00, 0, 0, 0, 0, 4'h0);
    #1;
    checks++; if (bus.RedirectV !== 1'b1) begin errors++; $display("FAIL b2b_second got=%b exp=1", bus.RedirectV); end
    @(negedge clk);
    #1;
    checks++; if (bus.RedirectV !== 1'b0 || bus.ExecCnt !== 16'd2) begin errors++; $display("FAIL b2b_end got=%b/%0d exp=0/2", bus.RedirectV, bus.ExecCnt); end
  endtask

  task automatic test_random();
    bit [3:0] m_flags;
    bit       m_redir;
    int       m_exec, m_squash;
    bit       cx, go, tk;
    do_reset();
    m_flags = 4'h0; m_redir = 1'b0; m_exec = 0; m_squash = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      set_in($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 2, 4'($urandom),
             2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             $urandom_range(0, 3) == 0, 4'($urandom));
      #1;
      cx = ref_cond(bus.CondE, m_flags);
      go = bus.ValidE && cx && !bus.StallE;
      tk = go && (bus.BranchE || bus.PCSrcE);
      checks++; if (bus.CondExE !== cx) begin errors++; $display("FAIL rnd_cond[%0d] got=%b exp=%b", i, bus.CondExE, cx); end
      checks++; if ({bus.PCSrcG, bus.RegWriteG, bus.MemWriteG} !== {bus.PCSrcE && go, bus.RegWriteE && go, bus.MemWriteE && go}) begin errors++; $display("FAIL rnd_gated[%0d] got=%b%b%b go=%b", i, bus.PCSrcG, bus.RegWriteG, bus.MemWriteG, go); end
      checks++; if (bus.FlushD !== tk || bus.FlushE !== tk) begin errors++; $display("FAIL rnd_flush[%0d] got=%b%b exp=%b", i, bus.FlushD, bus.FlushE, tk); end
      checks++; if (bus.FlagsOut !== m_flags || bus.RedirectV !== m_redir) begin errors++; $display("FAIL rnd_state[%0d] got=%b/%b exp=%b/%b", i, bus.FlagsOut, bus.RedirectV, m_flags, m_redir); end
      checks++; if (bus.ExecCnt !== 16'(m_exec) || bus.SquashCnt !== 16'(m_squash)) begin errors++; $display("FAIL rnd_cnt[%0d] got=%0d/%0d exp=%0d/%0d", i, bus.ExecCnt, bus.SquashCnt, m_exec, m_squash); end
      if (go && bus.FlagWriteE[1]) m_flags[3:2] = bus.ALUFlags[3:2];
      if (go && bus.FlagWriteE[0]) m_flags[1:0] = bus.ALUFlags[1:0];
      if (!bus.StallE) m_redir = tk;
      if (go) m_exec = m_exec + 1;
      if (bus.ValidE && !bus.StallE && !cx) m_squash = m_squash + 1;
    end
  endtask

  task automatic test_saturation();
    do_reset();
    @(negedge clk);
    set_in(1, 0, 4'hE, 2'b00, 0, 0, 0, 0, 4'h0);
    repeat (65534) @(posedge clk);
    #1;
    checks++; if (bus.ExecCnt !== 16'hFFFE) begin errors++; $display("FAIL sat_preload got=%h exp=fffe", bus.ExecCnt); end
    @(posedge clk); #1;
    checks++; if (bus.ExecCnt !== 16'hFFFF) begin errors++; $display("FAIL sat_max got=%h exp=ffff", bus.ExecCnt); end
    @(posedge clk); #1;
    checks++; if (bus.ExecCnt !== 16'hFFFF || bus.SquashCnt !== 16'd0) begin errors++; $display("FAIL sat_hold got=%h/%h exp=ffff/0000", bus.ExecCnt, bus.SquashCnt); end
  endtask

  task automatic test_reset_mid_redir();
    do_reset();
    @(negedge clk);
    set_in(1, 0, 4'hE, 2'b11, 0, 0, 0, 1, 4'b1010);
    @(negedge clk);
    set_in(0, 0, 4'h0, 2'b00, 0, 0, 0, 0, 4'h0);
    #1;
    checks++; if (bus.RedirectV !== 1'b1 || bus.FlagsOut !== 4'b1010) begin errors++; $display("FAIL midredir_pre got=%b/%b exp=1/1010", bus.RedirectV, bus.FlagsOut); end
    reset = 1'b0;
    #1;
    checks++; if (bus.RedirectV !== 1'b0 || bus.FlagsOut !== 4'b0000 || bus.ExecCnt !== 16'd0) begin errors++; $display("FAIL midredir_async got=%b/%b/%0d exp=0/0000/0", bus.RedirectV, bus.FlagsOut, bus.ExecCnt); end
    @(negedge clk);
    reset = 1'b1;
    set_in(1, 0, 4'h1, 2'b00, 0, 0, 0, 0, 4'h0);
    @(negedge clk);
    set_in(0, 0, 4'h0, 2'b00, 0, 0, 0, 0, 4'h0);
    #1;
    checks++; if (bus.ExecCnt !== 16'd1) begin errors++; $display("FAIL resume got=%0d exp=1", bus.ExecCnt); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b0;
    test_reset();
    test_eq_squash();
    test_flag_set();
    test_partial_flags();
    test_branch();
    test_back_to_back();
    test_random();
    test_reset_mid_redir();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
